jtbubl_vtiming: RTL
===================

// Module: jtbubl_vtiming
// PURPOSE
//  Parametrised video timing generator and successor to the fixed-timing counter used by the video top.
//  Produces H/V counters, render look-ahead rows, blanking and sync, a flip-aware dump row and a vertical-blank interrupt.
//  Also produces LHBL/LVBL copies delayed by a programmable number of pixels, so the colour mixer pipeline aligns.
//  Sits between the pixel clock-enable generator and the gfx/colmix blocks.
// PARAMETERS
//  HTOTAL   384  pixels per line; H counts 0..HTOTAL-1
//  HB_START 256  first blanked pixel; LHBL=0 when H>=HB_START or H<HB_END
//  HB_END   0    first visible pixel (0 = blank runs to line end)
//  HS_START 288  first HS pixel; HS=1 for HS_LEN pixels
//  HS_LEN   32   HS width in pixels (1..HTOTAL-HS_START)
//  V_START  16   first line number; V counts V_START..V_END
//  V_END    279  last line number, then wraps to V_START
//  VB_START 240  LVBL=0 when V>=VB_START
//  VS_START 256  first VS line; VS=1 for VS_LEN lines
//  VS_LEN   4    VS height in lines
//  DLY      0    LHBL_dly/LVBL_dly lag in pxl_cen ticks (0..15)
// PORTS
//  clk       in   1  system clock (48 MHz)
//  rst       in   1  synchronous, active-high reset
//  pxl_cen   in   1  pixel clock enable; all state advances only on pxl_cen=1
//  flip      in   1  screen flip; affects vdump only
//  H         out  9  horizontal count
//  vrender   out  9  V+1, wrapping V_END->V_START
//  vrender1  out  9  V+2, wrapping likewise
//  vdump     out  9  V, or V_START+V_END-V when flip=1
//  LHBL      out  1  horizontal blank, active low
//  LVBL      out  1  vertical blank, active low
//  LHBL_dly  out  1  LHBL delayed DLY pixels
//  LVBL_dly  out  1  LVBL delayed DLY pixels
//  HS        out  1  horizontal sync, active high
//  VS        out  1  vertical sync, active high
//  vint      out  1  one-clk pulse on entry to line VB_START
//  frame     out  1  toggles at each V wrap
// BEHAVIOUR
//  - Reset values: H=0, V=V_START, LHBL=LVBL=0, the _dly outputs and the delay line=0, HS=VS=0, vint=0, frame=0.
//  - On each pxl_cen tick, H increments. At H==HTOTAL-1, H wraps to 0 and V advances.
//  - V advances by one. At V==V_END, V wraps to V_START and frame toggles.
//  - All outputs are registered. A flag change takes effect on the same tick as the counter value it decodes, i.e. flags and counters are mutually consistent.
//  - LVBL and VS change only on the H wrap tick.
//  - HS is 1 for H in [HS_START, HS_START+HS_LEN).
//  - VS is 1 for V in [VS_START, VS_START+VS_LEN), computed with the same wrap as V.
//  - vint is high for exactly one clk, on the pxl_cen tick where V becomes VB_START. It does not repeat while V stays in blank.
//  - The vrender/vrender1 wrap uses (V_END-V_START+1) modulo arithmetic, so vrender1 at V=V_END-1 equals V_START.
//  - vdump follows the flip input with a one-clk register, not gated by pxl_cen.
//  - Delay line: a DLY-deep shift register of {LHBL,LVBL}, clocked on pxl_cen. DLY=0 makes the _dly outputs equal LHBL/LVBL.
//  - pxl_cen gaps of any length freeze all state. Outputs hold.
//  - rst asserted mid-frame restores the reset values on the next clk, regardless of pxl_cen. Counting resumes on the first pxl_cen after rst falls.
//  - Out-of-range parameter sets are not supported. An elaboration-time check fails when either condition holds:
//    - V_END<=V_START
//    - HB_START>=HTOTAL
// TESTING
//  - Default params, pxl_cen every 8 clk:
//    - 384 ticks per line and 264 lines per frame.
//    - LHBL=0 for exactly 128 ticks per line.
//    - LVBL=0 for 40 lines.
//  - vint: exactly one pulse per frame, coincident with V 239->240. frame toggles at 279->16.
//  - flip=1 at V=16 -> vdump=279. At V=279 -> vdump=16. vrender at V=279 =16, vrender1 at V=278 =16.
//  - DLY=3: LHBL_dly falls exactly 3 pxl_cen ticks after LHBL, with irregular pxl_cen spacing.
//  - HS starts at H=288 and lasts 32 ticks. VS spans V=256..259 and changes only at H wrap.
//  - rst pulsed at H=100,V=200 -> next clk H=0,V=16, all flags 0. Clean first full frame afterwards.

Source files
------------

// File: rtl/jtbubl_vtiming.sv
// rtl/jtbubl_vtiming.sv - parametrised video timing generator with delayed blanking copies
module jtbubl_vtiming #(
    parameter int HTOTAL   = 384,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 288,
    parameter int HS_LEN   = 32,
    parameter int V_START  = 16,
    parameter int V_END    = 279,
    parameter int VB_START = 240,
    parameter int VS_START = 256,
    parameter int VS_LEN   = 4,
    parameter int DLY      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       flip,
    output logic [8:0] H,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic [8:0] vdump,
    output logic       LHBL,
    output logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic       HS,
    output logic       VS,
    output logic       vint,
    output logic       frame
);

    localparam int VSPAN = V_END - V_START + 1;

    if (V_END <= V_START || HB_START >= HTOTAL) begin : g_bad_params
        $error("jtbubl_vtiming: unsupported parameter set");
    end

    // Line number n rows ahead, wrapping inside the V_START..V_END window
    function automatic logic [8:0] vadd(input logic [8:0] base, input int n);
        int t;
        t = int'(base) + n;
        if (t > V_END) t -= VSPAN;
        return 9'(t);
    endfunction

    // VS window may run past V_END and continue from V_START
    function automatic logic vs_on(input logic [8:0] vv);
        int off;
        off = int'(vv) - VS_START;
        if (off < 0) off += VSPAN;
        return off < VS_LEN;
    endfunction

    logic [8:0] v;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic [8:0] v_cur;
    logic       h_wrap;
    logic       v_last;

    // Next-state counter values; flags are decoded from these so they land with the counters
    always_comb begin
        h_wrap = (int'(H) == HTOTAL - 1);
        v_last = (int'(v) == V_END);
        h_nxt  = h_wrap ? 9'd0 : H + 9'd1;
        v_nxt  = v;
        if (h_wrap) v_nxt = v_last ? 9'(V_START) : v + 9'd1;
        v_cur  = pxl_cen ? v_nxt : v;
    end

    // Counters, look-ahead rows and blanking/sync flags
    always_ff @(posedge clk) begin
        if (rst) begin
            H        <= 9'd0;
            v        <= 9'(V_START);
            vrender  <= vadd(9'(V_START), 1);
            vrender1 <= vadd(9'(V_START), 2);
            LHBL     <= 1'b0;
            LVBL     <= 1'b0;
            HS       <= 1'b0;
            VS       <= 1'b0;
            vint     <= 1'b0;
            frame    <= 1'b0;
        end else begin
            vint <= 1'b0;
            if (pxl_cen) begin
                H        <= h_nxt;
                v        <= v_nxt;
                vrender  <= vadd(v_nxt, 1);
                vrender1 <= vadd(v_nxt, 2);
                LHBL     <= !(int'(h_nxt) >= HB_START || int'(h_nxt) < HB_END);
                HS       <= int'(h_nxt) >= HS_START && int'(h_nxt) < HS_START + HS_LEN;
                if (h_wrap) begin
                    LVBL <= int'(v_nxt) < VB_START;
                    VS   <= vs_on(v_nxt);
                    vint <= int'(v_nxt) == VB_START;
                    if (v_last) frame <= ~frame;
                end
            end
        end
    end

    // Dump row tracks flip every clk, using the row the counters are moving to
    always_ff @(posedge clk) begin
        if (rst) vdump <= 9'(V_START);
        else     vdump <= flip ? 9'(V_START + V_END) - v_cur : v_cur;
    end

    if (DLY == 0) begin : g_no_dly
        assign LHBL_dly = LHBL;
        assign LVBL_dly = LVBL;
    end else begin : g_dly
        logic [DLY-1:0] hb_sr;
        logic [DLY-1:0] vb_sr;

        // Pixel-rate shift line aligning blanking with the colour mixer pipeline
        always_ff @(posedge clk) begin
            if (rst) begin
                hb_sr <= '0;
                vb_sr <= '0;
            end else if (pxl_cen) begin
                hb_sr[0] <= LHBL;
                vb_sr[0] <= LVBL;
                for (int i = 1; i < DLY; i++) begin
                    hb_sr[i] <= hb_sr[i-1];
                    vb_sr[i] <= vb_sr[i-1];
                end
            end
        end

        assign LHBL_dly = hb_sr[DLY-1];
        assign LVBL_dly = vb_sr[DLY-1];
    end

endmodule
